// File: rtl/estagio_ex.sv
// Execute stage: ID/EX register, MEM/WB operand forwarding, ALU drive
// and EX/MEM capture of the ALU result for the memory stage.
//
// Ports:
//   clock, reset (async, active-low), parar (stall), anular (flush)
//   id_*            instruction fields presented by the decode stage
//   mem_*, wb_*     forwarding sources from the later stages
//   ula_A/B/op      operands and op driven to the external ALU
//   ula_resultado,
//   ula_zero        combinational ALU outputs fed back
//   exm_*           EX/MEM register outputs
module estagio_ex #(
    parameter int LARGURA  = 32,
    parameter int BITS_REG = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                parar,
    input  logic                anular,
    input  logic                id_valido,
    input  logic [2:0]          id_op,
    input  logic [BITS_REG-1:0] id_rs,
    input  logic [BITS_REG-1:0] id_rt,
    input  logic [BITS_REG-1:0] id_rd,
    input  logic [LARGURA-1:0]  id_rs_val,
    input  logic [LARGURA-1:0]  id_rt_val,
    input  logic [LARGURA-1:0]  id_imm,
    input  logic                id_usa_imm,
    input  logic                id_escreve_reg,
    input  logic [BITS_REG-1:0] mem_rd,
    input  logic                mem_escreve_reg,
    input  logic [LARGURA-1:0]  mem_valor,
    input  logic [BITS_REG-1:0] wb_rd,
    input  logic                wb_escreve_reg,
    input  logic [LARGURA-1:0]  wb_valor,
    output logic [LARGURA-1:0]  ula_A,
    output logic [LARGURA-1:0]  ula_B,
    output logic [2:0]          ula_op,
    input  logic [LARGURA-1:0]  ula_resultado,
    input  logic                ula_zero,
    output logic                exm_valido,
    output logic [LARGURA-1:0]  exm_resultado,
    output logic                exm_zero,
    output logic [BITS_REG-1:0] exm_rd,
    output logic                exm_escreve_reg,
    output logic [LARGURA-1:0]  exm_dado_rt
);

    typedef struct packed {
        logic                valido;
        logic [2:0]          op;
        logic [BITS_REG-1:0] rs;
        logic [BITS_REG-1:0] rt;
        logic [BITS_REG-1:0] rd;
        logic [LARGURA-1:0]  rs_val;
        logic [LARGURA-1:0]  rt_val;
        logic [LARGURA-1:0]  imm;
        logic                usa_imm;
        logic                escreve_reg;
    } id_ex_t;

    id_ex_t id_ex;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            id_ex <= '0;
        end else if (!parar) begin
            if (anular) begin
                id_ex.valido      <= 1'b0;
                id_ex.escreve_reg <= 1'b0;
            end else begin
                id_ex <= '{
                    valido:      id_valido,
                    op:          id_op,
                    rs:          id_rs,
                    rt:          id_rt,
                    rd:          id_rd,
                    rs_val:      id_rs_val,
                    rt_val:      id_rt_val,
                    imm:         id_imm,
                    usa_imm:     id_usa_imm,
                    escreve_reg: id_escreve_reg
                };
            end
        end
    end

    // Hit terms are made mutually exclusive so MEM takes precedence
    // over WB; register 0 never matches.
    logic mem_ok;
    logic wb_ok;
    logic mem_rs;
    logic wb_rs;
    logic mem_rt;
    logic wb_rt;

    assign mem_ok = mem_escreve_reg && (mem_rd != '0);
    assign wb_ok  = wb_escreve_reg && (wb_rd != '0);
    assign mem_rs = mem_ok && (mem_rd == id_ex.rs);
    assign mem_rt = mem_ok && (mem_rd == id_ex.rt);
    assign wb_rs  = wb_ok && (wb_rd == id_ex.rs) && !mem_rs;
    assign wb_rt  = wb_ok && (wb_rd == id_ex.rt) && !mem_rt;

    logic [LARGURA-1:0] fwd_rs;
    logic [LARGURA-1:0] fwd_rt;

    always_comb begin
        fwd_rs = id_ex.rs_val;
        unique case (1'b1)
            mem_rs:  fwd_rs = mem_valor;
            wb_rs:   fwd_rs = wb_valor;
            default: fwd_rs = id_ex.rs_val;
        endcase
    end

    always_comb begin
        fwd_rt = id_ex.rt_val;
        unique case (1'b1)
            mem_rt:  fwd_rt = mem_valor;
            wb_rt:   fwd_rt = wb_valor;
            default: fwd_rt = id_ex.rt_val;
        endcase
    end

    assign ula_A  = fwd_rs;
    assign ula_B  = id_ex.usa_imm ? id_ex.imm : fwd_rt;
    assign ula_op = id_ex.op;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            exm_valido      <= 1'b0;
            exm_resultado   <= '0;
            exm_zero        <= 1'b0;
            exm_rd          <= '0;
            exm_escreve_reg <= 1'b0;
            exm_dado_rt     <= '0;
        end else if (!parar) begin
            exm_valido      <= id_ex.valido;
            exm_resultado   <= ula_resultado;
            exm_zero        <= ula_zero;
            exm_rd          <= id_ex.rd;
            // Bubbles and writes to r0 must never reach the register file.
            exm_escreve_reg <= id_ex.escreve_reg && id_ex.valido
                               && (id_ex.rd != '0);
            // Store data is the forwarded rt even when B is the immediate.
            exm_dado_rt     <= fwd_rt;
        end
    end

endmodule

// File: tb/tb_estagio_ex.sv
// Bench for estagio_ex: directed cases plus random stimulus checked
// against a transaction-level model of the execute stage.
module tb_estagio_ex;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        parar, anular, id_valido;
    logic [2:0]  id_op;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rs_val, id_rt_val, id_imm;
    logic        id_usa_imm, id_escreve_reg;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_escreve_reg, wb_escreve_reg;
    logic [31:0] mem_valor, wb_valor;
    logic [31:0] ula_A, ula_B, ula_resultado;
    logic [2:0]  ula_op;
    logic        ula_zero;
    logic        exm_valido, exm_zero, exm_escreve_reg;
    logic [31:0] exm_resultado, exm_dado_rt;
    logic [4:0]  exm_rd;

    estagio_ex dut (
        .clock(clock), .reset(reset), .parar(parar), .anular(anular),
        .id_valido(id_valido), .id_op(id_op),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
        .id_usa_imm(id_usa_imm), .id_escreve_reg(id_escreve_reg),
        .mem_rd(mem_rd), .mem_escreve_reg(mem_escreve_reg),
        .mem_valor(mem_valor),
        .wb_rd(wb_rd), .wb_escreve_reg(wb_escreve_reg), .wb_valor(wb_valor),
        .ula_A(ula_A), .ula_B(ula_B), .ula_op(ula_op),
        .ula_resultado(ula_resultado), .ula_zero(ula_zero),
        .exm_valido(exm_valido), .exm_resultado(exm_resultado),
        .exm_zero(exm_zero), .exm_rd(exm_rd),
        .exm_escreve_reg(exm_escreve_reg), .exm_dado_rt(exm_dado_rt)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] alu(input logic [2:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a * b;
            3'd6:    return a << b[4:0];
            default: return a >> b[4:0];
        endcase
    endfunction

    // ALU sitting beside the stage.
    always_comb begin
        ula_resultado = alu(ula_op, ula_A, ula_B);
        ula_zero      = (ula_resultado == 32'd0);
    end

    typedef struct {
        logic        v;
        logic [2:0]  op;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rsv, rtv, imm;
        logic        ui, we;
    } ins_t;

    ins_t        m_ie;
    logic        mx_v, mx_z, mx_we;
    logic [31:0] mx_res, mx_dado;
    logic [4:0]  mx_rd;
    int          errs = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] r,
                                        input logic [31:0] lido);
        if (mem_escreve_reg && mem_rd != 5'd0 && mem_rd == r)
            return mem_valor;
        if (wb_escreve_reg && wb_rd != 5'd0 && wb_rd == r)
            return wb_valor;
        return lido;
    endfunction

    function automatic logic [31:0] exp_a();
        return fwd(m_ie.rs, m_ie.rsv);
    endfunction

    function automatic logic [31:0] exp_b();
        return m_ie.ui ? m_ie.imm : fwd(m_ie.rt, m_ie.rtv);
    endfunction

    task automatic model_reset();
        m_ie    = '{default: '0};
        mx_v    = 1'b0;
        mx_z    = 1'b0;
        mx_we   = 1'b0;
        mx_res  = 32'd0;
        mx_dado = 32'd0;
        mx_rd   = 5'd0;
    endtask

    task automatic check_all();
        chk("exm_valido", 32'(exm_valido), 32'(mx_v));
        chk("exm_escreve_reg", 32'(exm_escreve_reg), 32'(mx_we));
        if (mx_v) begin
            chk("exm_resultado", exm_resultado, mx_res);
            chk("exm_zero", 32'(exm_zero), 32'(mx_z));
            chk("exm_rd", 32'(exm_rd), 32'(mx_rd));
            chk("exm_dado_rt", exm_dado_rt, mx_dado);
        end
        if (m_ie.v) begin
            chk("ula_A", ula_A, exp_a());
            chk("ula_B", ula_B, exp_b());
            chk("ula_op", 32'(ula_op), 32'(m_ie.op));
        end
    endtask

    // One clock: model the edge from the inputs present before it.
    task automatic tick();
        ins_t        n_ie;
        logic        n_v, n_z, n_we;
        logic [31:0] n_res, n_dado;
        logic [4:0]  n_rd;
        n_ie   = m_ie;
        n_v    = mx_v;
        n_z    = mx_z;
        n_we   = mx_we;
        n_res  = mx_res;
        n_dado = mx_dado;
        n_rd   = mx_rd;
        if (!parar) begin
            n_v    = m_ie.v;
            n_res  = alu(m_ie.op, exp_a(), exp_b());
            n_z    = (n_res == 32'd0);
            n_rd   = m_ie.rd;
            n_dado = fwd(m_ie.rt, m_ie.rtv);
            n_we   = m_ie.v && m_ie.we && m_ie.rd != 5'd0;
            if (anular) begin
                n_ie.v  = 1'b0;
                n_ie.we = 1'b0;
            end else begin
                n_ie = '{v: id_valido, op: id_op, rs: id_rs, rt: id_rt,
                         rd: id_rd, rsv: id_rs_val, rtv: id_rt_val,
                         imm: id_imm, ui: id_usa_imm, we: id_escreve_reg};
            end
        end
        @(posedge clock);
        #1;
        m_ie    = n_ie;
        mx_v    = n_v;
        mx_z    = n_z;
        mx_we   = n_we;
        mx_res  = n_res;
        mx_dado = n_dado;
        mx_rd   = n_rd;
        check_all();
    endtask

    task automatic put(input logic [2:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] rsv, input logic [31:0] rtv,
                       input logic [31:0] imm, input logic ui,
                       input logic we);
        id_valido      = 1'b1;
        id_op          = op;
        id_rs          = rs;
        id_rt          = rt;
        id_rd          = rd;
        id_rs_val      = rsv;
        id_rt_val      = rtv;
        id_imm         = imm;
        id_usa_imm     = ui;
        id_escreve_reg = we;
    endtask

    function automatic logic [31:0] pick();
        if ($urandom_range(0, 3) == 0)
            return 32'($urandom_range(0, 3));
        return $urandom;
    endfunction

    initial begin
        parar = 0; anular = 0;
        put(3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        id_valido = 0;
        mem_rd = 0; mem_escreve_reg = 0; mem_valor = 0;
        wb_rd = 0; wb_escreve_reg = 0; wb_valor = 0;
        model_reset();

        #12;
        chk("rst_valido", 32'(exm_valido), 32'd0);
        chk("rst_resultado", exm_resultado, 32'd0);
        chk("rst_escreve", 32'(exm_escreve_reg), 32'd0);
        chk("rst_ula_op", 32'(ula_op), 32'd0);
        chk("rst_ula_A", ula_A, 32'd0);
        @(negedge clock);
        reset = 1;

        // basic add
        put(3'd0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 1'b0, 1'b1);
        tick();
        chk("add_ula_A", ula_A, 32'd5);
        id_valido = 0;
        tick();
        chk("add_res", exm_resultado, 32'd12);
        chk("add_zero", 32'(exm_zero), 32'd0);
        chk("add_rd", 32'(exm_rd), 32'd3);
        chk("add_we", 32'(exm_escreve_reg), 32'd1);

        // asynchronous reset mid-cycle
        #2;
        reset = 0;
        #1;
        chk("arst_valido", 32'(exm_valido), 32'd0);
        chk("arst_res", exm_resultado, 32'd0);
        chk("arst_rd", 32'(exm_rd), 32'd0);
        chk("arst_we", 32'(exm_escreve_reg), 32'd0);
        model_reset();
        @(negedge clock);
        reset = 1;

        // sub to zero, add wrap
        put(3'd1, 5'd1, 5'd2, 5'd4, 32'd9, 32'd9, 32'd0, 1'b0, 1'b1);
        tick();
        id_valido = 0;
        tick();
        chk("sub_zero", 32'(exm_zero), 32'd1);
        chk("sub_res", exm_resultado, 32'd0);
        put(3'd0, 5'd1, 5'd2, 5'd4, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b1);
        tick();
        id_valido = 0;
        tick();
        chk("wrap_res", exm_resultado, 32'd0);
        chk("wrap_zero", 32'(exm_zero), 32'd1);

        // forwarding priority
        put(3'd0, 5'd4, 5'd5, 5'd6, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1);
        mem_rd = 4; mem_escreve_reg = 1; mem_valor = 100;
        wb_rd = 4; wb_escreve_reg = 1; wb_valor = 200;
        tick();
        chk("fwd_mem", ula_A, 32'd100);
        mem_escreve_reg = 0;
        #1;
        chk("fwd_wb", ula_A, 32'd200);
        id_valido = 0;
        tick();
        wb_escreve_reg = 0;

        // register 0 never forwarded nor written
        put(3'd0, 5'd0, 5'd1, 5'd0, 32'd0, 32'd3, 32'd0, 1'b0, 1'b1);
        mem_rd = 0; mem_escreve_reg = 1; mem_valor = 55;
        tick();
        chk("r0_ula_A", ula_A, 32'd0);
        id_valido = 0;
        tick();
        chk("r0_we", 32'(exm_escreve_reg), 32'd0);
        chk("r0_valido", 32'(exm_valido), 32'd1);
        mem_escreve_reg = 0;

        // immediate operand with forwarded store data
        put(3'd0, 5'd1, 5'd6, 5'd7, 32'd10, 32'd0, 32'hFFFF_FFFC,
            1'b1, 1'b1);
        mem_rd = 6; mem_escreve_reg = 1; mem_valor = 77;
        tick();
        chk("imm_ula_B", ula_B, 32'hFFFF_FFFC);
        id_valido = 0;
        tick();
        chk("imm_res", exm_resultado, 32'd6);
        chk("imm_dado", exm_dado_rt, 32'd77);
        mem_escreve_reg = 0;

        // stall, flush, and stall+flush together
        put(3'd0, 5'd1, 5'd2, 5'd5, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1);
        tick();
        put(3'd1, 5'd1, 5'd2, 5'd8, 32'd20, 32'd4, 32'd0, 1'b0, 1'b1);
        tick();
        parar = 1;
        put(3'd4, 5'd1, 5'd2, 5'd9, 32'd8, 32'd3, 32'd0, 1'b0, 1'b1);
        tick();
        tick();
        chk("stall_res", exm_resultado, 32'd3);
        chk("stall_rd", 32'(exm_rd), 32'd5);
        chk("stall_ula_A", ula_A, 32'd20);
        parar = 0; anular = 1;
        tick();
        chk("flush_res", exm_resultado, 32'd16);
        anular = 0; id_valido = 0;
        tick();
        chk("flush_valido", 32'(exm_valido), 32'd0);
        chk("flush_we", 32'(exm_escreve_reg), 32'd0);
        put(3'd3, 5'd1, 5'd2, 5'd10, 32'hF0, 32'h0F, 32'd0, 1'b0, 1'b1);
        tick();
        parar = 1; anular = 1;
        tick();
        chk("both_ula_op", 32'(ula_op), 32'd3);
        chk("both_ula_A", ula_A, 32'hF0);
        parar = 0; anular = 0; id_valido = 0;
        tick();
        chk("both_valido", 32'(exm_valido), 32'd1);
        chk("both_res", exm_resultado, 32'hFF);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            parar           = ($urandom_range(0, 9) < 2);
            anular          = ($urandom_range(0, 9) < 2);
            id_valido       = ($urandom_range(0, 3) != 0);
            id_op           = 3'($urandom);
            id_rs           = 5'($urandom_range(0, 7));
            id_rt           = 5'($urandom_range(0, 7));
            id_rd           = 5'($urandom_range(0, 7));
            id_rs_val       = pick();
            id_rt_val       = pick();
            id_imm          = pick();
            id_usa_imm      = 1'($urandom);
            id_escreve_reg  = 1'($urandom);
            mem_rd          = 5'($urandom_range(0, 7));
            mem_escreve_reg = 1'($urandom);
            mem_valor       = pick();
            wb_rd           = 5'($urandom_range(0, 7));
            wb_escreve_reg  = 1'($urandom);
            wb_valor        = pick();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/estagio_ex.md
Name: estagio_ex

Overview:
- Execute-stage pipeline slice wrapped around the 3-bit-op ALU.
- Holds the ID/EX register and resolves operand forwarding from the MEM and WB stages.
- Drives the ALU operands and op, and captures the ALU result and zero flag into the EX/MEM register for the memory stage.
- The ALU is instantiated beside this block, not inside it.

Parameters:
- LARGURA, 32, datapath width of operands and result.
- BITS_REG, 5, register-index width (32 architectural registers; register 0 is hardwired zero).

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- parar  in  1  stall: freeze ID/EX and EX/MEM.
- anular  in  1  flush: load a bubble into ID/EX.
- id_valido  in  1  ID stage presents a valid instruction.
- id_op  in  3  ALU op: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 mul, 6 shl, 7 shr.
- id_rs, id_rt, id_rd  in  BITS_REG each  source and destination indices.
- id_rs_val, id_rt_val  in  LARGURA  register-file read data.
- id_imm  in  LARGURA  sign-extended immediate.
- id_usa_imm  in  1  operand B = immediate.
- id_escreve_reg  in  1  instruction writes rd.
- mem_rd  in  BITS_REG; mem_escreve_reg  in  1; mem_valor  in  LARGURA  MEM-stage forwarding source.
- wb_rd  in  BITS_REG; wb_escreve_reg  in  1; wb_valor  in  LARGURA  WB-stage forwarding source.
- ula_A, ula_B  out  LARGURA  ALU operands.
- ula_op  out  3  ALU op.
- ula_resultado  in  LARGURA; ula_zero  in  1  ALU outputs (combinational from ula_*).
- exm_valido  out  1; exm_resultado  out  LARGURA; exm_zero  out  1; exm_rd  out  BITS_REG; exm_escreve_reg  out  1; exm_dado_rt  out  LARGURA (forwarded rt, for stores).

Behaviour:
- Reset: asynchronous, effective immediately when reset=0. Clears all ID/EX and EX/MEM state to 0, so every exm_* output is 0 and ula_op=0. ula_A and ula_B follow forwarding from the zeroed fields.
- ID/EX register update, at each rising edge with reset=1:
  - parar=1: hold. parar has priority over anular; the controller keeps anular asserted until parar drops.
  - else anular=1: valid<=0, escreve_reg<=0, other fields don't-care.
  - else: capture all id_* fields, with valid<=id_valido.
- Forwarding, combinational from ID/EX fields. Operand rs value:
  - mem_valor if mem_escreve_reg && mem_rd!=0 && mem_rd==rs;
  - else wb_valor if wb_escreve_reg && wb_rd!=0 && wb_rd==rs;
  - else the latched rs_val.
  - MEM wins over WB. Register 0 is never forwarded.
  - rt is forwarded identically.
- ALU drive:
  - ula_A = forwarded rs.
  - ula_B = latched imm if usa_imm, else forwarded rt.
  - ula_op = latched op.
- EX/MEM register update, at each rising edge with reset=1:
  - parar=1: hold.
  - else: exm_valido<=valid; exm_resultado<=ula_resultado; exm_zero<=ula_zero; exm_rd<=rd; exm_dado_rt<=forwarded rt (also when usa_imm).
  - exm_escreve_reg<=escreve_reg && valid && rd!=0.
- Latency: id_* sampled at edge N → ula_* valid after N → exm_* valid after edge N+1. Throughput is one instruction per clock.
- Arithmetic: wrap-around modulo 2^LARGURA is performed by the ALU; this block does no width extension.
- Bubbles (valid=0) propagate with exm_escreve_reg=0, whatever the ALU computes.

Test Plan:
- Reset, then id_op=0, rs_val=5, rt_val=7, rd=3, escreve=1, valid=1 at edge 1 → after edge 2: exm_resultado=12, exm_zero=0, exm_rd=3, exm_escreve_reg=1. Assert reset=0 asynchronously mid-cycle → exm_* = 0 immediately.
- op=1 with rs_val=9, rt_val=9 → exm_zero=1, exm_resultado=0. op=0 with 0xFFFFFFFF + 1 → exm_resultado=0, exm_zero=1 (wrap).
- rs=4, mem_rd=4 (mem_valor=100), wb_rd=4 (wb_valor=200), both writes enabled → ula_A=100. Drop mem_escreve_reg → ula_A=200.
- rs=0, mem_rd=0, mem_escreve_reg=1, mem_valor=55, rs_val=0 → ula_A=0 (no forward). rd=0 with escreve=1 → exm_escreve_reg=0.
- usa_imm=1, imm=0xFFFFFFFC, op=0, rs_val=10, rt matches mem_rd (mem_valor=77) → ula_B=0xFFFFFFFC, exm_resultado=6, exm_dado_rt=77.
- parar=1 for 2 cycles while id_* changes → ID/EX and exm_* unchanged. anular=1 (parar=0) → next exm_valido=0, exm_escreve_reg=0. parar=1 and anular=1 together → hold, no bubble.
